// File: rtl/alu_op_queue.sv
// Request FIFO in front of the 32-bit ALU: valid/ready in and out, illegal-opcode
// screening, synchronous flush and occupancy reporting. All outputs are registered.
module alu_op_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_A,
  input  logic [DATA_WIDTH-1:0]   in_B,
  input  logic [2:0]              in_ALUop,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_A,
  output logic [DATA_WIDTH-1:0]   out_B,
  output logic [2:0]              out_ALUop,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    bad_op
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 2 * DATA_WIDTH + 3 + TAG_WIDTH;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_in_ready, r_out_valid, r_bad_op;
  logic [ENT_W-1:0] r_head;

  logic             w_op_legal, w_hs, w_push, w_pop, w_bad_hs;
  logic [PTR_W-1:0] w_rd_nxt, w_wr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ENT_W-1:0] w_in_ent, w_head_nxt;

  assign w_in_ent = {in_A, in_B, in_ALUop, in_tag};

  always_comb begin
    w_op_legal = 1'b0;
    case (in_ALUop)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: w_op_legal = 1'b1;
      default:                                w_op_legal = 1'b0;
    endcase
  end

  assign w_hs     = in_valid & r_in_ready & ~flush;
  assign w_push   = w_hs & w_op_legal;
  assign w_bad_hs = w_hs & ~w_op_legal;
  assign w_pop    = r_out_valid & out_ready & ~flush;

  // Next pointers/count; flush overrides any push or pop in the same cycle.
  always_comb begin
    w_rd_nxt  = r_rd_ptr;
    w_wr_nxt  = r_wr_ptr;
    w_cnt_nxt = r_count;
    if (flush) begin
      w_rd_nxt  = '0;
      w_wr_nxt  = '0;
      w_cnt_nxt = '0;
    end else begin
      if (w_push) w_wr_nxt = PTR_W'(r_wr_ptr + PTR_W'(1));
      if (w_pop)  w_rd_nxt = PTR_W'(r_rd_ptr + PTR_W'(1));
      case ({w_push, w_pop})
        2'b10:   w_cnt_nxt = CNT_W'(r_count + CNT_W'(1));
        2'b01:   w_cnt_nxt = CNT_W'(r_count - CNT_W'(1));
        default: w_cnt_nxt = r_count;
      endcase
    end
  end

  // The next head is the incoming op when it lands exactly at the next read slot.
  always_comb begin
    w_head_nxt = '0;
    if (w_cnt_nxt == '0)
      w_head_nxt = '0;
    else if (w_push && (w_rd_nxt == r_wr_ptr))
      w_head_nxt = w_in_ent;
    else
      w_head_nxt = r_mem[w_rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bad_op    <= 1'b0;
      r_head      <= '0;
    end else begin
      r_rd_ptr    <= w_rd_nxt;
      r_wr_ptr    <= w_wr_nxt;
      r_count     <= w_cnt_nxt;
      r_in_ready  <= (w_cnt_nxt != CNT_W'(DEPTH));
      r_out_valid <= (w_cnt_nxt != '0);
      r_bad_op    <= r_bad_op | w_bad_hs;
      r_head      <= w_head_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign count     = r_count;
  assign bad_op    = r_bad_op;
  assign {out_A, out_B, out_ALUop, out_tag} = r_head;

endmodule

// File: tb/tb_alu_op_queue.sv
// Directed, table-driven bench for alu_op_queue with hand-computed expectations.
module tb_alu_op_queue;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, bad_op;
  logic [31:0] in_A, in_B, out_A, out_B;
  logic [2:0]  in_ALUop, out_ALUop, count;
  logic [3:0]  in_tag, out_tag;

  int errors = 0;
  int checks = 0;

  alu_op_queue #(.DATA_WIDTH(32), .DEPTH(4), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_ALUop(in_ALUop), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_A(out_A), .out_B(out_B), .out_ALUop(out_ALUop), .out_tag(out_tag),
    .count(count), .bad_op(bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic        ordy, fl;
    logic        eov;
    logic [31:0] ea, eb;
    logic [2:0]  eop;
    logic [3:0]  etag;
    logic [2:0]  ecnt;
    logic        eir, ebad;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic iv, input int a, input int b, input logic [2:0] op,
                     input int tag, input logic ordy, input logic fl,
                     input logic eov, input int ea, input int eb, input logic [2:0] eop,
                     input int etag, input int ecnt, input logic eir, input logic ebad);
    vec_t v;
    v.iv = iv; v.a = 32'(a); v.b = 32'(b); v.op = op; v.tag = 4'(tag);
    v.ordy = ordy; v.fl = fl;
    v.eov = eov; v.ea = 32'(ea); v.eb = 32'(eb); v.eop = eop; v.etag = 4'(etag);
    v.ecnt = 3'(ecnt); v.eir = eir; v.ebad = ebad;
    vq.push_back(v);
  endtask

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return {31'd0, $signed(a) < $signed(b)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic eov, input logic [31:0] ea,
                       input logic [31:0] eb, input logic [2:0] eop, input logic [3:0] etag,
                       input logic [2:0] ecnt, input logic eir, input logic ebad);
    logic [76:0] got, exp;
    got = {out_valid, out_A, out_B, out_ALUop, out_tag, count, in_ready, bad_op};
    exp = {eov, ea, eb, eop, etag, ecnt, eir, ebad};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ov=%0b A=%0h B=%0h op=%0b tag=%0d cnt=%0d ir=%0b bad=%0b, want ov=%0b A=%0h B=%0h op=%0b tag=%0d cnt=%0d ir=%0b bad=%0b",
               name, out_valid, out_A, out_B, out_ALUop, out_tag, count, in_ready, bad_op,
               eov, ea, eb, eop, etag, ecnt, eir, ebad);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.iv; in_A = v.a; in_B = v.b; in_ALUop = v.op; in_tag = v.tag;
    out_ready = v.ordy; flush = v.fl;
  endtask

  initial begin
    logic [2:0]  ops [4];
    logic [31:0] res;
    int          tg;
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110;

    // Drain the single op left by the first hand-written push.
    add(0, 0, 0, 3'b000, 0, 1, 0,  0, 0, 0, 3'b000, 0, 0, 1, 0);
    // Fill to DEPTH with out_ready low; head stays at tag 0.
    for (int t = 0; t < 4; t++)
      add(1, 10 + t, t, ops[t], t, 0, 0,  1, 10, 0, 3'b000, 0, t + 1, (t < 3), 0);
    add(1, 99, 99, 3'b010, 5, 0, 0,  1, 10, 0, 3'b000, 0, 4, 0, 0);
    // Full with in_valid and out_ready: only the pop happens.
    add(1, 77, 77, 3'b010, 6, 1, 0,  1, 11, 1, 3'b001, 1, 3, 1, 0);
    for (int t = 2; t < 4; t++)
      add(0, 0, 0, 3'b000, 0, 1, 0,  1, 10 + t, t, ops[t], t, 4 - t, 1, 0);
    add(0, 0, 0, 3'b000, 0, 1, 0,  0, 0, 0, 3'b000, 0, 0, 1, 0);
    // Steady state at count 2 with simultaneous push/pop, wrapping pointers.
    add(1, 20, 4, 3'b010, 4, 0, 0,  1, 20, 4, 3'b010, 4, 1, 1, 0);
    add(1, 21, 5, 3'b010, 5, 0, 0,  1, 20, 4, 3'b010, 4, 2, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      tg = 5 + k;
      add(1, tg + 16, tg, 3'b010, tg, 1, 0,  1, tg + 15, tg - 1, 3'b010, tg - 1, 2, 1, 0);
    end
    add(0, 0, 0, 3'b000, 0, 1, 0,  1, 31, 15, 3'b010, 15, 1, 1, 0);
    add(0, 0, 0, 3'b000, 0, 1, 0,  0, 0, 0, 3'b000, 0, 0, 1, 0);
    // Illegal opcode dropped, sticky flag; following SUB stored.
    add(1, 1, 1, 3'b011, 7, 0, 0,  0, 0, 0, 3'b000, 0, 0, 1, 1);
    add(1, 9, 4, 3'b110, 8, 0, 0,  1, 9, 4, 3'b110, 8, 1, 1, 1);
    // Reach count 3, then flush with push and pop both presented.
    add(1, 2, 2, 3'b000, 9, 0, 0,  1, 9, 4, 3'b110, 8, 2, 1, 1);
    add(1, 3, 3, 3'b111, 10, 0, 0, 1, 9, 4, 3'b110, 8, 3, 1, 1);
    add(1, 7, 7, 3'b010, 11, 1, 1, 0, 0, 0, 3'b000, 0, 0, 1, 1);
    add(0, 0, 0, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 0, 0, 1, 1);
    // Two entries queued ahead of the asynchronous reset.
    add(1, 4, 5, 3'b000, 12, 0, 0, 1, 4, 5, 3'b000, 12, 1, 1, 1);
    add(1, 6, 6, 3'b001, 13, 0, 0, 1, 4, 5, 3'b000, 12, 2, 1, 1);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_A = '0; in_B = '0; in_ALUop = '0; in_tag = '0;
    #12;
    check("reset", 0, 0, 0, 3'b000, 0, 0, 1, 0);
    @(negedge clk) rst_n = 1'b1;

    // First op: ADD 5+3 visible the next cycle; attached ALU yields 8.
    @(negedge clk);
    in_valid = 1'b1; in_A = 32'd5; in_B = 32'd3; in_ALUop = 3'b010; in_tag = 4'd1;
    @(posedge clk); #1;
    check("first_push", 1, 5, 3, 3'b010, 1, 1, 1, 0);
    res = alu(out_ALUop, out_A, out_B);
    checks++;
    if (res !== 32'd8) begin
      errors++;
      $display("FAIL alu_result: got %0d want 8", res);
    end

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vq[i].eov, vq[i].ea, vq[i].eb, vq[i].eop, vq[i].etag,
            vq[i].ecnt, vq[i].eir, vq[i].ebad);
    end

    // Asynchronous reset between clock edges must clear state immediately.
    #2;
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 3'b000, 0, 0, 1, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", 0, 0, 0, 3'b000, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
